// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the S/R flip-flop drive controller.
//   sr_state_t        : controller FSM state, 3-bit encoding
//   SR_PULSE_CYCLES   : default cycles S or R is held high per request
//   SR_TIMEOUT_CYCLES : default cycles to wait for Q/Qbar confirmation
//   sr_cnt_width()    : counter width able to hold max(pulse, timeout)
package sr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } sr_state_t;

  localparam int SR_PULSE_CYCLES   = 2;
  localparam int SR_TIMEOUT_CYCLES = 8;

  function automatic int sr_cnt_width(input int pulse_cycles, input int timeout_cycles);
    int m;
    m = (pulse_cycles > timeout_cycles) ? pulse_cycles : timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_drive_controller_if.sv
// Bundle of the controller's request handshake and flip-flop drive/feedback.
// Handshake: a request transfers at a rising clock edge where req_valid and
// req_ready are both 1; the requester holds req_valid and req_value stable
// until that edge, and req_value carries no meaning while req_valid is 0.
//   master : requester / flip-flop side (drives request and Q/Qbar feedback)
//   slave  : controller side (drives ready, S/R and status pulses)
interface sr_drive_controller_if;
  logic req_valid;
  logic req_value;
  logic req_ready;
  logic Q_fb;
  logic Qbar_fb;
  logic S;
  logic R;
  logic done;
  logic err;
  logic busy;

  modport master (
    output req_valid, req_value, Q_fb, Qbar_fb,
    input  req_ready, S, R, done, err, busy
  );

  modport slave (
    input  req_valid, req_value, Q_fb, Qbar_fb,
    output req_ready, S, R, done, err, busy
  );
endinterface

// File: rtl/sr_cycle_counter.sv
// Loadable down-counter shared by the pulse and wait phases.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   load     : load load_val this edge (wins over dec)
//   load_val : value to load
//   dec      : decrement this edge; holds at zero
//   zero     : count is zero
module sr_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_drive_controller.sv
// Drives S/R of an sr_flip_flop to a requested level and confirms it on Q/Qbar.
//   Clk, Rst  : rising-edge clock, synchronous active-high reset
//   bus       : request handshake, S/R drive, Q/Qbar feedback, done/err/busy
//   state_dbg : current FSM state
// A request whose level is already present completes without any pulse.
// Otherwise S (or R) is held for PULSE_CYCLES, then feedback is checked every
// edge for up to TIMEOUT_CYCLES; Q_fb==Qbar_fb never counts as a match.
module sr_drive_controller
  import sr_ctrl_pkg::*;
#(
  parameter int PULSE_CYCLES   = SR_PULSE_CYCLES,
  parameter int TIMEOUT_CYCLES = SR_TIMEOUT_CYCLES
) (
  input  logic                 Clk,
  input  logic                 Rst,
  sr_drive_controller_if.slave bus,
  output sr_state_t            state_dbg
);

  localparam int CNT_W = sr_cnt_width(PULSE_CYCLES, TIMEOUT_CYCLES);

  sr_state_t  state;
  logic       tgt;
  logic       fb_valid;
  logic       fb_match;
  logic       idle_match;
  logic       handshake;
  logic       cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic       cnt_dec;
  logic       cnt_zero;

  assign fb_valid   = (bus.Q_fb != bus.Qbar_fb);
  assign fb_match   = fb_valid && (bus.Q_fb == tgt);
  // In IDLE the target is not latched yet, so compare against the request.
  assign idle_match = fb_valid && (bus.Q_fb == bus.req_value);
  assign handshake  = bus.req_valid && bus.req_ready;
  assign state_dbg  = state;

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (handshake && !idle_match) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(PULSE_CYCLES - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(TIMEOUT_CYCLES - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_dec = !fb_match && !cnt_zero;
      end
      default: ;
    endcase
  end

  sr_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk      (Clk),
    .rst      (Rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= ST_IDLE;
      tgt           <= 1'b0;
      bus.S         <= 1'b0;
      bus.R         <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.req_ready <= 1'b1;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            tgt           <= bus.req_value;
            bus.busy      <= 1'b1;
            bus.req_ready <= 1'b0;
            if (idle_match) begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
            end else begin
              state <= ST_PULSE;
              bus.S <= bus.req_value;
              bus.R <= !bus.req_value;
            end
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            state <= ST_WAIT;
            bus.S <= 1'b0;
            bus.R <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (fb_match) begin
            state    <= ST_DONE;
            bus.done <= 1'b1;
          end else if (cnt_zero) begin
            state   <= ST_ERR;
            bus.err <= 1'b1;
          end
        end
        default: begin
          // DONE and ERR last one cycle, then accept the next request.
          state         <= ST_IDLE;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_drive_controller.sv
module tb_sr_drive_controller;
  import sr_ctrl_pkg::*;

  localparam int P = 2;
  localparam int T = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr_drive_controller_if bus ();
  sr_state_t state_dbg;

  sr_drive_controller dut (
    .Clk       (clk),
    .Rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- flip-flop model in the loop ----------------
  // mode 0: working S/R flip-flop, 1: stuck Q=0/Qbar=1,
  // 2: stuck Q=Qbar=1, 3: stuck Q=Qbar=0
  logic       ff_q;
  logic       preset_en  = 1'b0;
  logic       preset_val = 1'b0;
  int         ff_mode    = 0;

  always @(posedge clk) begin
    if (preset_en)                 ff_q <= preset_val;
    else if (bus.S && !bus.R)      ff_q <= 1'b1;
    else if (bus.R && !bus.S)      ff_q <= 1'b0;
  end

  always_comb begin
    bus.Q_fb    = ff_q;
    bus.Qbar_fb = ~ff_q;
    case (ff_mode)
      1: begin bus.Q_fb = 1'b0; bus.Qbar_fb = 1'b1; end
      2: begin bus.Q_fb = 1'b1; bus.Qbar_fb = 1'b1; end
      3: begin bus.Q_fb = 1'b0; bus.Qbar_fb = 1'b0; end
      default: ;
    endcase
  end

  // Invariants checked on every cycle of every test.
  always @(negedge clk) begin
    total++;
    if ((bus.S & bus.R) !== 1'b0) begin
      bad++;
      $display("FAIL s_and_r t=%0t got S=%b R=%b want S&R=0", $time, bus.S, bus.R);
    end
    total++;
    if ((bus.done & bus.err) !== 1'b0) begin
      bad++;
      $display("FAIL done_and_err t=%0t got done=%b err=%b want not both", $time, bus.done, bus.err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preset_ff(input logic v);
    preset_en  = 1'b1;
    preset_val = v;
    @(posedge clk);
    #1 preset_en = 1'b0;
    @(negedge clk);
  endtask

  // One request from handshake to return to IDLE, checked cycle by cycle
  // against the expected trace derived from the timing rules.
  task automatic run_request(input logic tgt, input bit toggle_busy, input string name);
    bit matched, works, ok;
    int end_cycle, wait_cnt;
    logic exp_s, exp_r, exp_done, exp_err, exp_busy;
    logic [5:0] exp_q[$];

    case (ff_mode)
      0:       matched = (ff_q === tgt);
      1:       matched = (tgt == 1'b0);
      default: matched = 1'b0;
    endcase
    works     = (ff_mode == 0);
    end_cycle = matched ? 1 : (works ? P + 2 : P + T + 1);

    for (int i = 1; i <= end_cycle + 1; i++) begin
      exp_s    = !matched && tgt  && (i <= P);
      exp_r    = !matched && !tgt && (i <= P);
      exp_done = (i == end_cycle) && (matched || works);
      exp_err  = (i == end_cycle) && !(matched || works);
      exp_busy = (i <= end_cycle);
      exp_q.push_back({exp_s, exp_r, exp_done, exp_err, exp_busy, !exp_busy});
    end

    bus.req_valid = 1'b1;
    bus.req_value = tgt;
    wait_cnt = 0;
    while (bus.req_ready !== 1'b1 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_timeout got ready=%b want 1 within 50 cycles", name, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);

    for (int i = 1; i <= end_cycle + 1; i++) begin
      logic [5:0] exp, got;
      @(negedge clk);
      exp = exp_q.pop_front();
      got = {bus.S, bus.R, bus.done, bus.err, bus.busy, bus.req_ready};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s cycle=%0d got {S,R,done,err,busy,ready}=%b want %b", name, i, got, exp);
      end
      if (toggle_busy && i < end_cycle) begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_value = 1'($urandom_range(0, 1));
      end else begin
        bus.req_valid = 1'b0;
      end
    end

    if (works) begin
      ok = (ff_q === tgt);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s_ff_level got Q=%b want %b", name, ff_q, tgt);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0] got;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_value = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {bus.S, bus.R, bus.done, bus.err, bus.busy, bus.req_ready};
    total++;
    if (got !== 6'b000001) begin
      bad++;
      $display("FAIL reset got {S,R,done,err,busy,ready}=%b want 000001", got);
    end
    rst = 1'b0;
    @(negedge clk);
    got = {bus.S, bus.R, bus.done, bus.err, bus.busy, bus.req_ready};
    total++;
    if (got !== 6'b000001) begin
      bad++;
      $display("FAIL reset_release got {S,R,done,err,busy,ready}=%b want 000001", got);
    end
  endtask

  task automatic test_set_from_q0();
    ff_mode = 0;
    preset_ff(1'b0);
    run_request(1'b1, 1'b0, "set_from_q0");
  endtask

  task automatic test_reset_from_q1();
    ff_mode = 0;
    preset_ff(1'b1);
    run_request(1'b0, 1'b0, "reset_from_q1");
  endtask

  task automatic test_already_matching();
    ff_mode = 0;
    preset_ff(1'b1);
    run_request(1'b1, 1'b0, "match_q1");
    run_request(1'b0, 1'b0, "reset_after_match");
    run_request(1'b0, 1'b0, "match_q0");
  endtask

  task automatic test_timeout();
    ff_mode = 1;
    run_request(1'b1, 1'b0, "timeout_stuck0");
    ff_mode = 2;
    run_request(1'b1, 1'b0, "timeout_both1");
    ff_mode = 3;
    run_request(1'b0, 1'b0, "timeout_both0");
    ff_mode = 0;
  endtask

  task automatic test_mid_pulse_reset();
    logic [5:0] got;
    ff_mode = 0;
    preset_ff(1'b0);
    bus.req_valid = 1'b1;
    bus.req_value = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if ({bus.S, bus.R} !== 2'b10) begin
      bad++;
      $display("FAIL midrst_first_s got S,R=%b%b want 10", bus.S, bus.R);
    end
    @(negedge clk);
    total++;
    if ({bus.S, bus.R} !== 2'b10) begin
      bad++;
      $display("FAIL midrst_second_s got S,R=%b%b want 10", bus.S, bus.R);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      got = {bus.S, bus.R, bus.done, bus.err, bus.busy, bus.req_ready};
      total++;
      if (got !== 6'b000001) begin
        bad++;
        $display("FAIL midrst_after cycle=%0d got {S,R,done,err,busy,ready}=%b want 000001", i, got);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_request();
    ff_mode = 0;
    preset_ff(1'b0);
    run_request(1'b1, 1'b1, "busy_set");
    ff_mode = 2;
    run_request(1'b0, 1'b1, "busy_timeout");
    ff_mode = 0;
  endtask

  task automatic test_back_to_back();
    ff_mode = 0;
    preset_ff(1'b1);
    run_request(1'b0, 1'b0, "b2b_0");
    run_request(1'b1, 1'b0, "b2b_1");
    run_request(1'b1, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int gap;
      ff_mode = int'($urandom_range(0, 5) > 3 ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 7) == 0) preset_ff(1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      run_request(1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "random");
    end
    ff_mode = 0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_value = 1'b0;
    test_reset();
    test_set_from_q0();
    test_reset_from_q1();
    test_already_matching();
    test_timeout();
    test_mid_pulse_reset();
    test_busy_request();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
